// File: rtl/conv3x3_window_fetch.sv
// Read-side controller for a triple-read frame RAM. It issues row r-1/r/r+1 addresses
// and shifts the returned columns into a 3x3 window, which it streams over valid/ready.
`timescale 1ns/1ps
module conv3x3_window_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   read_addr1,
    output logic [ADDR_WIDTH-1:0]   read_addr2,
    output logic [ADDR_WIDTH-1:0]   read_addr3,
    input  logic [DATA_WIDTH-1:0]   q1,
    input  logic [DATA_WIDTH-1:0]   q2,
    input  logic [DATA_WIDTH-1:0]   q3,
    output logic [9*DATA_WIDTH-1:0] win,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [ADDR_WIDTH-1:0]   win_row,
    output logic [ADDR_WIDTH-1:0]   win_col
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW-1:0] ROW_STEP  = AW'(IMG_W);
    localparam logic [AW-1:0] ROW_STEP2 = AW'(2 * IMG_W);
    localparam logic [AW-1:0] LAST_FR   = AW'(IMG_H - 2);
    localparam logic [AW-1:0] LAST_FC   = AW'(IMG_W - 1);
    localparam logic [AW-1:0] LAST_WC   = AW'(IMG_W - 2);

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    state_t         state;
    logic [AW-1:0]  nxt_fr, nxt_fc, nxt_base;
    logic           issuing;
    logic           a_valid, q_valid, hold_valid;
    logic [AW-1:0]  a_row, a_col, q_row, q_col, hold_row, hold_col;
    logic [DW-1:0]  hold1, hold2, hold3;
    logic [AW-1:0]  col_cnt;
    logic [DW-1:0]  pix [9];

    logic           advance, last_accept, src_valid;
    logic [AW-1:0]  src_row, src_col, new_cnt;
    logic [DW-1:0]  src1, src2, src3;

    // a_* tags the address register, q_* tags what the RAM output currently holds;
    // hold_* keeps the unconsumed q word when a stall makes the RAM re-read ahead.
    assign advance     = (state == STREAM) && (!win_valid || win_ready);
    assign last_accept = win_valid && win_ready && (win_row == LAST_FR) && (win_col == LAST_WC);
    assign src_valid   = hold_valid | q_valid;
    assign src_row     = hold_valid ? hold_row : q_row;
    assign src_col     = hold_valid ? hold_col : q_col;
    assign src1        = hold_valid ? hold1 : q1;
    assign src2        = hold_valid ? hold2 : q2;
    assign src3        = hold_valid ? hold3 : q3;
    assign new_cnt     = (src_col == '0) ? AW'(1) : col_cnt + AW'(1);

    always_comb begin
        win = '0;
        for (int i = 0; i < 9; i++) win[i*DW +: DW] = pix[i];
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            read_addr1 <= '0;
            read_addr2 <= '0;
            read_addr3 <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            nxt_fr     <= '0;
            nxt_fc     <= '0;
            nxt_base   <= '0;
            issuing    <= 1'b0;
            a_valid    <= 1'b0;
            a_row      <= '0;
            a_col      <= '0;
            q_valid    <= 1'b0;
            q_row      <= '0;
            q_col      <= '0;
            hold_valid <= 1'b0;
            hold_row   <= '0;
            hold_col   <= '0;
            hold1      <= '0;
            hold2      <= '0;
            hold3      <= '0;
            col_cnt    <= '0;
            for (int i = 0; i < 9; i++) pix[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    q_valid    <= 1'b0;
                    hold_valid <= 1'b0;
                    if (start) begin
                        state      <= STREAM;
                        busy       <= 1'b1;
                        read_addr1 <= '0;
                        read_addr2 <= ROW_STEP;
                        read_addr3 <= ROW_STEP2;
                        a_valid    <= 1'b1;
                        a_row      <= AW'(1);
                        a_col      <= '0;
                        nxt_fr     <= AW'(1);
                        nxt_fc     <= AW'(1);
                        nxt_base   <= '0;
                        issuing    <= 1'b1;
                        col_cnt    <= '0;
                        win_valid  <= 1'b0;
                    end
                end
                STREAM: begin
                    q_valid <= a_valid;
                    q_row   <= a_row;
                    q_col   <= a_col;
                    if (last_accept) begin
                        state      <= FINISH;
                        done       <= 1'b1;
                        win_valid  <= 1'b0;
                        a_valid    <= 1'b0;
                        hold_valid <= 1'b0;
                        issuing    <= 1'b0;
                    end else if (advance) begin
                        hold_valid <= 1'b0;
                        if (issuing) begin
                            read_addr1 <= nxt_base + nxt_fc;
                            read_addr2 <= nxt_base + ROW_STEP + nxt_fc;
                            read_addr3 <= nxt_base + ROW_STEP2 + nxt_fc;
                            a_valid    <= 1'b1;
                            a_row      <= nxt_fr;
                            a_col      <= nxt_fc;
                            if (nxt_fc == LAST_FC) begin
                                nxt_fc   <= '0;
                                nxt_fr   <= nxt_fr + AW'(1);
                                nxt_base <= nxt_base + ROW_STEP;
                                if (nxt_fr == LAST_FR) issuing <= 1'b0;
                            end else begin
                                nxt_fc <= nxt_fc + AW'(1);
                            end
                        end else begin
                            a_valid <= 1'b0;
                        end
                        if (src_valid) begin
                            pix[0]  <= pix[1];
                            pix[1]  <= pix[2];
                            pix[2]  <= src1;
                            pix[3]  <= pix[4];
                            pix[4]  <= pix[5];
                            pix[5]  <= src2;
                            pix[6]  <= pix[7];
                            pix[7]  <= pix[8];
                            pix[8]  <= src3;
                            col_cnt <= new_cnt;
                            if (new_cnt >= AW'(3)) begin
                                win_row <= src_row;
                                win_col <= new_cnt - AW'(2);
                            end
                            win_valid <= (new_cnt >= AW'(3));
                        end else begin
                            win_valid <= 1'b0;
                        end
                    end else if (!hold_valid && q_valid) begin
                        hold_valid <= 1'b1;
                        hold_row   <= q_row;
                        hold_col   <= q_col;
                        hold1      <= q1;
                        hold2      <= q2;
                        hold3      <= q3;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    q_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv3x3_window_fetch.sv
// Bench for conv3x3_window_fetch: a triple-port RAM model, a window-list reference
// built from the frame contents, directed corner sequences and randomized backpressure.
`timescale 1ns/1ps
module tb_conv3x3_window_fetch;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int W  = 32;
    localparam int H  = 32;

    typedef struct packed {
        logic [9*DW-1:0] win;
        logic [AW-1:0]   row;
        logic [AW-1:0]   col;
    } win_t;

    typedef struct {
        int idx;
        int row;
        int col;
        int w0;
        int w4;
        int w8;
    } vec_t;

    logic            clock, reset, start, busy, done, win_valid, win_ready;
    logic [AW-1:0]   read_addr1, read_addr2, read_addr3, win_row, win_col;
    logic [DW-1:0]   q1, q2, q3;
    logic [9*DW-1:0] win;

    logic [DW-1:0] mem [W*H];
    win_t          exp_q[$];
    win_t          got_q[$];
    int            got_cyc[$];
    int            done_cyc[$];
    int            n_checks, n_fail, done_cnt, cyc, ready_mode;
    logic [194:0]  snap, prev_snap;
    bit            prev_stall;

    conv3x3_window_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(W), .IMG_H(H)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .read_addr1(read_addr1), .read_addr2(read_addr2), .read_addr3(read_addr3),
        .q1(q1), .q2(q2), .q3(q3), .win(win), .win_valid(win_valid),
        .win_ready(win_ready), .win_row(win_row), .win_col(win_col)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        q1 <= mem[read_addr1];
        q2 <= mem[read_addr2];
        q3 <= mem[read_addr3];
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 0) win_ready = 1'b1;
            else if (ready_mode == 1) win_ready = ($urandom_range(3, 0) != 0);
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            snap = {win, win_row, win_col, read_addr1, read_addr2, read_addr3, win_valid};
            if (prev_stall) check("stall_freeze", 256'(snap), 256'(prev_snap));
            prev_stall = win_valid && !win_ready;
            prev_snap  = snap;
            if (win_valid && win_ready) begin
                got_q.push_back({win, win_row, win_col});
                got_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
        end
    end

    // Every interior centre (r,c) in raster order; the window is the 3x3 neighbourhood.
    task automatic build_expected();
        exp_q.delete();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                win_t e;
                e.row = AW'(r);
                e.col = AW'(c);
                e.win = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.win[(3*i+j)*DW +: DW] = mem[(r - 1 + i) * W + (c - 1 + j)];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_count"}, 256'(got_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("%s_win%0d", tag, i), 256'(got_q[i]), 256'(exp_q[i]));
    endtask

    task automatic run_frame(input int mode, input bit extra_start, input bit check_lat);
        bit           stalled;
        logic [194:0] frz;
        stalled = 1'b0;
        got_q.delete();
        got_cyc.delete();
        done_cyc.delete();
        done_cnt   = 0;
        ready_mode = mode;
        win_ready  = 1'b1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        check("busy_on_start", 256'(busy), 256'(1));
        if (check_lat) begin
            check("first_addr", 256'({read_addr1, read_addr2, read_addr3}),
                  256'({10'd0, 10'd32, 10'd64}));
            for (int e = 1; e <= 4; e++) begin
                @(posedge clock); #1;
                check($sformatf("latency_edge%0d", e), 256'(win_valid), 256'(e == 4));
            end
            check("first_centre", 256'({win_row, win_col}), 256'({10'd1, 10'd1}));
        end
        for (int k = 0; k < 20000 && done_cnt == 0; k++) begin
            @(posedge clock); #1;
            if (extra_start && k == 200) start = 1'b1;
            if (extra_start && k == 201) start = 1'b0;
            if (mode == 2 && !stalled && got_q.size() >= 45) begin
                stalled   = 1'b1;
                win_ready = 1'b0;
                frz = {win, win_row, win_col, read_addr1, read_addr2, read_addr3, win_valid};
                repeat (5) @(posedge clock);
                #1;
                check("stall5_frozen", 256'({win, win_row, win_col, read_addr1, read_addr2,
                      read_addr3, win_valid}), 256'(frz));
                win_ready = 1'b1;
            end
        end
        check("done_seen", 256'(done_cnt != 0), 256'(1));
        repeat (5) @(posedge clock);
        #1;
        check("done_once", 256'(done_cnt), 256'(1));
        check("idle_after", 256'({busy, win_valid}), 256'(0));
        if (got_cyc.size() > 0 && done_cyc.size() > 0)
            check("done_latency", 256'(done_cyc[0]), 256'(got_cyc[got_cyc.size()-1] + 1));
    endtask

    initial begin
        vec_t tab[5];
        n_checks = 0; n_fail = 0; cyc = 0; done_cnt = 0;
        reset = 1'b1; start = 1'b0; win_ready = 1'b0; ready_mode = 3;
        for (int a = 0; a < W * H; a++) mem[a] = DW'(a);

        tab[0] = '{idx: 0,   row: 1,  col: 1,  w0: 0,   w4: 33,  w8: 66};
        tab[1] = '{idx: 29,  row: 1,  col: 30, w0: 29,  w4: 62,  w8: 95};
        tab[2] = '{idx: 30,  row: 2,  col: 1,  w0: 32,  w4: 65,  w8: 98};
        tab[3] = '{idx: 450, row: 16, col: 1,  w0: 480, w4: 513, w8: 546};
        tab[4] = '{idx: 899, row: 30, col: 30, w0: 957, w4: 990, w8: 1023};

        repeat (3) @(posedge clock);
        #1;
        check("reset_ctrl", 256'({busy, done, win_valid}), 256'(0));
        check("reset_addr", 256'({read_addr1, read_addr2, read_addr3}), 256'(0));
        check("reset_coords", 256'({win_row, win_col}), 256'(0));
        check("reset_win", 256'(win), 256'(0));
        @(negedge clock) reset = 1'b0;

        // Full-rate pass over an address-valued frame.
        build_expected();
        run_frame(0, 1'b0, 1'b1);
        compare_all("plain");
        for (int t = 0; t < 5; t++) begin
            if (tab[t].idx < got_q.size()) begin
                check($sformatf("table%0d", t),
                      256'({got_q[tab[t].idx].row, got_q[tab[t].idx].col,
                            got_q[tab[t].idx].win[0*DW +: DW], got_q[tab[t].idx].win[4*DW +: DW],
                            got_q[tab[t].idx].win[8*DW +: DW]}),
                      256'({AW'(tab[t].row), AW'(tab[t].col), DW'(tab[t].w0),
                            DW'(tab[t].w4), DW'(tab[t].w8)}));
            end
        end
        if (got_cyc.size() >= 900) begin
            check("gap_in_row", 256'(got_cyc[1] - got_cyc[0]), 256'(1));
            check("gap_row1_2", 256'(got_cyc[30] - got_cyc[29]), 256'(3));
            check("gap_row11_12", 256'(got_cyc[330] - got_cyc[329]), 256'(3));
            check("gap_row29_30", 256'(got_cyc[870] - got_cyc[869]), 256'(3));
        end

        // Five-cycle backpressure in the middle of a row.
        run_frame(2, 1'b0, 1'b0);
        compare_all("stall5");

        // A second start while busy must not restart the pass.
        run_frame(0, 1'b1, 1'b0);
        compare_all("restart_ignored");

        // Asynchronous abort mid-row, then a clean restart.
        got_q.delete();
        got_cyc.delete();
        ready_mode = 0;
        win_ready  = 1'b1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int k = 0; k < 2000 && got_q.size() < 40; k++) @(posedge clock);
        check("abort_reached_mid_row", 256'(got_q.size() >= 40), 256'(1));
        #3 reset = 1'b1;
        #1;
        check("abort_ctrl", 256'({busy, done, win_valid, win_row, win_col}), 256'(0));
        check("abort_addr", 256'({read_addr1, read_addr2, read_addr3}), 256'(0));
        check("abort_win", 256'(win), 256'(0));
        done_cnt = 0;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("abort_no_done", 256'(done_cnt), 256'(0));
        check("abort_idle", 256'(busy), 256'(0));
        run_frame(0, 1'b0, 1'b1);
        compare_all("after_reset");

        // Random frame contents under random backpressure.
        for (int a = 0; a < W * H; a++) mem[a] = DW'($urandom);
        build_expected();
        run_frame(1, 1'b0, 1'b0);
        compare_all("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
